// File: rtl/mcycle_pkg.sv
// Shared definitions for the MCycle arbiter.
//   MC_*        : MCycleOp encodings driven on mc_op / req_op
//   arb_state_t : arbiter sequencing states
package mcycle_pkg;

  localparam logic [1:0] MC_SMUL = 2'b00;
  localparam logic [1:0] MC_UMUL = 2'b01;
  localparam logic [1:0] MC_SDIV = 2'b10;
  localparam logic [1:0] MC_UDIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   pointer : highest-priority requester index for this round
//   grant   : one-hot grant to the first requester at or after pointer (wrapping)
//   index   : binary index of the granted requester
//   any     : at least one request present
module rr_arbiter #(
  parameter int  N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest valid requester
  // (lowest rotation offset from pointer) is the last one written and wins.
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (((int'(pointer) + k) % N_REQ) == j && req[j]) begin
          grant    = '0;
          grant[j] = 1'b1;
          index    = IDX_W'(j);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mcycle_arbiter.sv
// Shares one MCycle multiply/divide unit among N_REQ requesters.
// Round-robin grant in IDLE, one Start pulse sequence per accepted request,
// result capture on Busy fall, valid/ready response with requester ID.
// A watchdog aborts an ISSUE/WAIT phase after TIMEOUT cycles with rsp_err=1.
// Ports:
//   CLK, RESET                    clock, synchronous active-low reset
//   req_valid/req_ready           per-requester handshake (ready is one-hot)
//   req_op/req_op1/req_op2        packed per-requester op and operands
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/rsp_result1/2/rsp_err  response payload
//   mc_start/mc_op/mc_operand1/2  to MCycle
//   mc_result1/2/mc_busy          from MCycle
module mcycle_arbiter
  import mcycle_pkg::*;
#(
  parameter int  N_REQ   = 2,
  parameter int  WIDTH   = 32,
  parameter int  TIMEOUT = 256,
  localparam int IDX_W   = $clog2(N_REQ),
  localparam int WD_W    = $clog2(TIMEOUT)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_op1,
  input  logic [WIDTH*N_REQ-1:0] req_op2,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDX_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]       rsp_result1,
  output logic [WIDTH-1:0]       rsp_result2,
  output logic                   rsp_err,
  output logic                   mc_start,
  output logic [1:0]             mc_op,
  output logic [WIDTH-1:0]       mc_operand1,
  output logic [WIDTH-1:0]       mc_operand2,
  input  logic [WIDTH-1:0]       mc_result1,
  input  logic [WIDTH-1:0]       mc_result2,
  input  logic                   mc_busy
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [IDX_W-1:0] id_q,    id_d;
  logic [WD_W-1:0]  wd_q,    wd_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] opa_q,   opa_d;
  logic [WIDTH-1:0] opb_q,   opb_d;
  logic [WIDTH-1:0] res1_q,  res1_d;
  logic [WIDTH-1:0] res2_q,  res2_d;
  logic             err_q,   err_d;

  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             wd_expired;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req     (req_valid),
    .pointer (ptr_q),
    .grant   (gnt),
    .index   (gnt_idx),
    .any     (gnt_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt[j]) begin
        sel_op = req_op[2*j +: 2];
        sel_a  = req_op1[WIDTH*j +: WIDTH];
        sel_b  = req_op2[WIDTH*j +: WIDTH];
      end
    end
  end

  // Last permitted ISSUE/WAIT cycle: counter started at 0 on the first
  // ISSUE cycle, so TIMEOUT cycles have elapsed when we leave from here.
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    wd_d      = wd_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res1_d    = res1_q;
    res2_d    = res2_q;
    err_d     = err_q;
    req_ready = '0;
    mc_start  = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Gated by RESET so every output reads 0 while reset is held.
        req_ready = RESET ? gnt : '0;
        if (gnt_any) begin
          op_d    = sel_op;
          opa_d   = sel_a;
          opb_d   = sel_b;
          id_d    = gnt_idx;
          wd_d    = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wd_expired) begin
          res1_d  = '0;
          res2_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          mc_start = 1'b1;
          wd_d     = wd_q + WD_W'(1);
          if (mc_busy) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A completing operation takes precedence over a simultaneous abort.
        if (!mc_busy) begin
          res1_d  = mc_result1;
          res2_d  = mc_result2;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wd_expired) begin
          res1_d  = '0;
          res2_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          ptr_d   = (id_q == IDX_W'(N_REQ - 1)) ? '0 : id_q + IDX_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      wd_q    <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      wd_q    <= wd_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      err_q   <= err_d;
    end
  end

  assign rsp_id      = id_q;
  assign rsp_result1 = res1_q;
  assign rsp_result2 = res2_q;
  assign rsp_err     = err_q;
  assign mc_op       = op_q;
  assign mc_operand1 = opa_q;
  assign mc_operand2 = opb_q;

endmodule

// File: tb/tb_mcycle_arbiter.sv
module tb_mcycle_arbiter;
  import mcycle_pkg::*;

  localparam int N_REQ   = 2;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 3;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [3:0]       req_op = '0;
  logic [7:0]       req_op1 = '0;
  logic [7:0]       req_op2 = '0;
  logic [1:0]       req_ready;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic             rsp_id;
  logic [3:0]       rsp_result1, rsp_result2;
  logic             rsp_err;
  logic             mc_start;
  logic [1:0]       mc_op;
  logic [3:0]       mc_operand1, mc_operand2;
  logic [3:0]       mc_result1, mc_result2;
  logic             mc_busy;

  mcycle_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_op(req_op), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result1(rsp_result1), .rsp_result2(rsp_result2), .rsp_err(rsp_err),
    .mc_start(mc_start), .mc_op(mc_op), .mc_operand1(mc_operand1), .mc_operand2(mc_operand2),
    .mc_result1(mc_result1), .mc_result2(mc_result2), .mc_busy(mc_busy)
  );

  always #5 CLK = ~CLK;

  // Reference MCycle: returns {result2, result1}
  function automatic logic [7:0] mc_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic signed [3:0] sa, sb, q, r;
    logic signed [7:0] sp;
    sa = a;
    sb = b;
    case (op)
      MC_SMUL: begin sp = sa * sb; return sp; end
      MC_UMUL: return {4'b0, a} * {4'b0, b};
      MC_SDIV: begin q = sa / sb; r = sa % sb; return {r, q}; end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Behavioural MCycle: Busy high with Start, stays high LAT more cycles.
  int         m_cnt = 0;
  logic [3:0] m_r1 = '0, m_r2 = '0;
  logic       stuck_busy = 1'b0;
  always @(posedge CLK) begin
    if (!RESET) m_cnt <= 0;
    else if (m_cnt == 0 && mc_start) begin
      {m_r2, m_r1} <= mc_model(mc_op, mc_operand1, mc_operand2);
      m_cnt <= LAT;
    end else if (m_cnt != 0) m_cnt <= m_cnt - 1;
  end
  assign mc_busy    = (m_cnt != 0) || mc_start || stuck_busy;
  assign mc_result1 = m_r1;
  assign mc_result2 = m_r2;

  typedef struct packed {
    logic       id;
    logic [3:0] r1;
    logic [3:0] r2;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rsp_cnt = 0;
  int   busy_rise = 0;
  logic busy_prev = 1'b0;
  logic stuck_prev = 1'b0;
  logic fall_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor / scoreboard consumer
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      sb.delete();
      fall_pend = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (fall_pend) check("busy_fall_to_rsp_valid", rsp_valid, 1);
      fall_pend = 1'b0;
      if (busy_prev && !mc_busy && !stuck_prev) begin
        check("mc_start_at_busy_fall", mc_start, 0);
        fall_pend = 1'b1;
      end
      if (!busy_prev && mc_busy) busy_rise++;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("rsp_unexpected_sb_size", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_result1", rsp_result1, e.r1);
          check("rsp_result2", rsp_result2, e.r2);
          check("rsp_err", rsp_err, e.err);
        end
        rsp_cnt++;
      end
      busy_prev = mc_busy;
    end
    stuck_prev = stuck_busy;
  end

  task automatic push_exp(input logic idx, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic [7:0] r;
    r = mc_model(op, a, b);
    e.id = idx; e.r1 = r[3:0]; e.r2 = r[7:4]; e.err = 1'b0;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic idx, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b, input bit push);
    if (idx) begin req_op[3:2] = op; req_op1[7:4] = a; req_op2[7:4] = b; end
    else     begin req_op[1:0] = op; req_op1[3:0] = a; req_op2[3:0] = b; end
    req_valid[idx] = 1'b1;
    if (push) push_exp(idx, op, a, b);
  endtask

  task automatic wait_accept(input logic idx);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge CLK);
      if (RESET && req_valid[idx] && req_ready[idx]) seen = 1'b1;
    end
    check($sformatf("accept_req%0d", idx), seen, 1);
    @(posedge CLK); #1;
    check("accept_to_mc_start", mc_start, 1);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int c = 0;
    do begin @(posedge CLK); c++; end while (rsp_cnt < target && c < 200);
    check("rsp_count_reached", rsp_cnt >= target, 1);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b0; req_valid = '0; rsp_ready = 1'b1; stuck_busy = 1'b0;
    @(posedge CLK); #1;
    check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_result1, rsp_result2, rsp_err,
                            mc_start, mc_op, mc_operand1, mc_operand2}, 0);
    RESET = 1'b1;
  endtask

  initial begin
    int b0, base, n;

    // Reset state
    do_reset();

    // 1: single unsigned multiply
    b0 = busy_rise;
    drive_req(1'b0, MC_UMUL, 4'hF, 4'hF, 1'b1);
    wait_accept(1'b0);
    wait_rsp(1);
    check("t1_busy_pulses", busy_rise - b0, 1);

    // 2: simultaneous requests from fresh pointer
    do_reset();
    base = rsp_cnt;
    drive_req(1'b0, MC_UMUL, 4'hF, 4'hF, 1'b1);
    drive_req(1'b1, MC_SDIV, 4'hC, 4'h3, 1'b1);
    wait_accept(1'b0);
    wait_accept(1'b1);
    wait_rsp(base + 2);

    // 3: both held valid for four operations -> 0,1,0,1
    do_reset();
    base = rsp_cnt;
    drive_req(1'b0, MC_SMUL, 4'hD, 4'h5, 1'b1);
    drive_req(1'b1, MC_UDIV, 4'hD, 4'h4, 1'b1);
    push_exp(1'b0, MC_SMUL, 4'hD, 4'h5);
    push_exp(1'b1, MC_UDIV, 4'hD, 4'h4);
    wait_rsp(base + 4);
    req_valid = '0;

    // 4: consumer stalls the response for five cycles
    do_reset();
    base = rsp_cnt;
    rsp_ready = 1'b0;
    drive_req(1'b0, MC_UMUL, 4'h7, 4'h9, 1'b1);
    wait_accept(1'b0);
    drive_req(1'b1, MC_UMUL, 4'h3, 4'h5, 1'b1);
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge CLK); n++; end
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge CLK);
      check($sformatf("t4_hold_cycle%0d", i),
            {rsp_valid, rsp_id, rsp_result1, rsp_result2, rsp_err, req_ready, mc_start},
            {1'b1, 1'b0, 4'hF, 4'h3, 1'b0, 2'b00, 1'b0});
    end
    @(posedge CLK); #1;
    rsp_ready = 1'b1;
    wait_rsp(base + 1);
    wait_accept(1'b1);
    wait_rsp(base + 2);

    // 5: reset while MCycle is busy
    do_reset();
    base = rsp_cnt;
    drive_req(1'b0, MC_UMUL, 4'hB, 4'h6, 1'b0);
    wait_accept(1'b0);
    n = 0;
    do begin @(negedge CLK); n++; end while (!(mc_busy && !mc_start) && n < 40);
    @(posedge CLK); #1;
    RESET = 1'b0;
    req_valid[0] = 1'b1;
    @(posedge CLK); #1;
    check("t5_outputs_after_reset", {req_ready, rsp_valid, rsp_id, rsp_result1, rsp_result2,
                                     rsp_err, mc_start, mc_op, mc_operand1, mc_operand2}, 0);
    RESET = 1'b1;
    push_exp(1'b0, MC_UMUL, 4'hB, 4'h6);
    wait_accept(1'b0);
    wait_rsp(base + 1);
    check("t5_single_response", rsp_cnt - base, 1);

    // 6: Busy stuck high -> watchdog abort after TIMEOUT cycles
    do_reset();
    base = rsp_cnt;
    stuck_busy = 1'b1;
    drive_req(1'b1, MC_UDIV, 4'h9, 4'h2, 1'b0);
    sb.push_back('{id: 1'b1, r1: 4'h0, r2: 4'h0, err: 1'b1});
    wait_accept(1'b1);
    n = 0;
    @(negedge CLK);
    while (!rsp_valid && n < 40) begin @(negedge CLK); n++; end
    check("t6_watchdog_latency", n, TIMEOUT);
    check("t6_mc_start_low", mc_start, 0);
    wait_rsp(base + 1);
    stuck_busy = 1'b0;

    // Error flag is per response
    drive_req(1'b0, MC_SMUL, 4'hD, 4'h5, 1'b1);
    wait_accept(1'b0);
    wait_rsp(base + 2);

    check("sb_empty_at_end", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
